// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry
// constants and the odd-parity helper used when a byte is latched.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_transmitter_if.sv
// Host transmitter bundle: command handshake plus open-drain PS/2 pins.
// slave = transmitter side, master = user/pad side.
interface ps2_host_transmitter_if import ps2_pkg::*; ();

    logic                 Start;
    logic [DATA_BITS-1:0] TxData;
    logic                 Busy;
    logic                 Done;
    logic                 AckError;
    logic                 PS2ClkIn;
    logic                 PS2ClkOE;
    logic                 PS2DataIn;
    logic                 PS2DataOE;

    modport slave (
        input  Start, TxData, PS2ClkIn, PS2DataIn,
        output Busy, Done, AckError, PS2ClkOE, PS2DataOE
    );

    modport master (
        output Start, TxData, PS2ClkIn, PS2DataIn,
        input  Busy, Done, AckError, PS2ClkOE, PS2DataOE
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Synchroniser for one asynchronous PS/2 line plus a falling-edge strobe.
// Ports: clk, rst (sync, active high), line (pin), level (synced), fall.
module ps2_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              last;

    // Idle PS/2 lines float high, so reset to 1 to avoid a false fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            last   <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line};
            last   <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign fall  = last & ~level;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, RTS, 11-bit frame, ACK check.
// Ports: CLK, Reset (sync, active high), bus (slave: Start/TxData in,
// Busy/Done/AckError out, PS/2 pin levels in, pin output-enables out).
// Define PS2_TX_TIMEOUT_EN to abort a silent or stuck device.
module ps2_host_transmitter import ps2_pkg::*; #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    ps2_host_transmitter_if.slave bus
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    ps2_state_e           state, state_n;
    logic [INH_W-1:0]     inh_cnt, inh_cnt_n;
    logic [3:0]           idx, idx_n, idx_inc;
    logic [DATA_BITS-1:0] tx, tx_n;
    logic                 par, par_n;
    logic                 err, err_n;
    logic                 clk_oe, clk_oe_n;
    logic                 data_oe, data_oe_n;
    logic                 done, ack_error;
    logic                 clk_lvl, clk_fall;
    logic                 data_lvl, data_fall_unused;
    logic                 timeout;

    ps2_line_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk   (CLK),
        .rst   (Reset),
        .line  (bus.PS2ClkIn),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_sync #(.STAGES(SYNC_STAGES)) u_data_sync (
        .clk   (CLK),
        .rst   (Reset),
        .line  (bus.PS2DataIn),
        .level (data_lvl),
        .fall  (data_fall_unused)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            active;

    // Runs from clock release until the transaction leaves the device phase.
    assign active  = state inside {RTS, SEND, ACK, WAIT_IDLE};
    assign timeout = active && (to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK) begin
        if (Reset || !active) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    assign idx_inc = (idx == 4'hF) ? idx : idx + 4'd1;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            inh_cnt <= '0;
            idx     <= '0;
            tx      <= '0;
            par     <= 1'b0;
            err     <= 1'b0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
        end else begin
            state   <= state_n;
            inh_cnt <= inh_cnt_n;
            idx     <= idx_n;
            tx      <= tx_n;
            par     <= par_n;
            err     <= err_n;
            clk_oe  <= clk_oe_n;
            data_oe <= data_oe_n;
        end
    end

    always_comb begin
        state_n   = state;
        inh_cnt_n = inh_cnt;
        idx_n     = idx;
        tx_n      = tx;
        par_n     = par;
        err_n     = err;
        clk_oe_n  = clk_oe;
        data_oe_n = data_oe;
        done      = 1'b0;
        ack_error = 1'b0;

        unique case (state)
            IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (bus.Start) begin
                    tx_n      = bus.TxData;
                    par_n     = odd_parity(bus.TxData);
                    idx_n     = '0;
                    err_n     = 1'b0;
                    inh_cnt_n = '0;
                    clk_oe_n  = 1'b1;
                    data_oe_n = (INHIBIT_CYCLES == 1);
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (int'(inh_cnt) == INHIBIT_CYCLES - 1) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    state_n   = RTS;
                end else begin
                    inh_cnt_n = inh_cnt + INH_W'(1);
                    // Start bit goes low only in the last inhibit cycle.
                    data_oe_n = (int'(inh_cnt) == INHIBIT_CYCLES - 2);
                end
            end
            RTS: begin
                data_oe_n = 1'b1;
                if (clk_fall) begin
                    data_oe_n = ~tx[0];
                    idx_n     = 4'd1;
                    state_n   = SEND;
                end
            end
            SEND: begin
                // idx is the frame position currently on the line.
                if (clk_fall) begin
                    idx_n = idx_inc;
                    unique case (1'b1)
                        (idx < 4'(DATA_BITS)):
                            data_oe_n = ~tx[idx[2:0]];
                        (idx == 4'(DATA_BITS)):
                            data_oe_n = ~par;
                        (idx_inc == 4'(FRAME_BITS - 1)): begin
                            data_oe_n = 1'b0;
                            state_n   = ACK;
                        end
                        default: begin
                            data_oe_n = 1'b0;
                            state_n   = ACK;
                        end
                    endcase
                end
            end
            ACK: begin
                data_oe_n = 1'b0;
                if (clk_fall) begin
                    err_n   = data_lvl;
                    state_n = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_lvl && data_lvl) begin
                    done      = 1'b1;
                    ack_error = err;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (timeout) begin
            done      = 1'b1;
            ack_error = 1'b1;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            state_n   = IDLE;
        end
    end

    assign bus.Busy      = (state != IDLE);
    assign bus.Done      = done;
    assign bus.AckError  = ack_error;
    assign bus.PS2ClkOE  = clk_oe;
    assign bus.PS2DataOE = data_oe;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: wired-AND pins, PS/2 device model,
// frame model and per-cycle handshake monitor.
module tb_ps2_host_transmitter;

    localparam int INH = 20;
    localparam int TO  = 600;
    localparam int H   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    always #5 clk = ~clk;

    ps2_host_transmitter_if bus ();

    assign bus.PS2ClkIn  = ~(bus.PS2ClkOE | dev_clk_low);
    assign bus.PS2DataIn = ~(bus.PS2DataOE | dev_data_low);

    ps2_host_transmitter #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame as the device must see it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_model(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Busy: set by a Start seen while idle, cleared the cycle after Done.
    logic mb = 1'b0;
    logic rst_seen = 1'b0;
    logic armed = 1'b0;

    always @(posedge clk) begin
        rst_seen <= rst;
        armed    <= armed | rst;
        if (rst) mb <= 1'b0;
        else if (!mb && bus.Start) mb <= 1'b1;
        else if (mb && bus.Done) mb <= 1'b0;
    end

    int cyc = 0;
    int m_done = 0;
    int m_falls = 0;
    int m_inh = 0;
    int m_inh_data = 0;
    int rel_cyc = 0;
    int done_cyc = 0;
    logic m_err = 1'b0;
    logic [1:0] m_oe_done = 2'b00;
    logic p_clkin = 1'b1;
    logic p_cloe = 1'b0;
    logic p_doe = 1'b0;
    logic p_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (armed) begin
            check("busy", bus.Busy, mb);
            if (bus.AckError) check("ackerr_without_done", bus.Done, 1);
            if (p_clkin && !bus.PS2ClkIn && !bus.PS2ClkOE) m_falls++;
            if (bus.PS2ClkOE) m_inh++;
            if (bus.PS2ClkOE && bus.PS2DataOE) m_inh_data++;
            if (p_cloe && !bus.PS2ClkOE && !rst_seen) rel_cyc = cyc;
            if (bus.Done) begin
                m_done++;
                m_err     = bus.AckError;
                done_cyc  = cyc;
                m_oe_done = {bus.PS2ClkOE, bus.PS2DataOE};
            end
            if (bus.PS2DataOE !== p_doe && !bus.PS2ClkOE && !p_cloe &&
                !rst_seen && !p_done)
                check("data_change_clk_low", bus.PS2ClkIn, 0);
        end
        p_clkin = bus.PS2ClkIn;
        p_cloe  = bus.PS2ClkOE;
        p_doe   = bus.PS2DataOE;
        p_done  = bus.Done;
    end

    task automatic clear_mon();
        m_done = 0;
        m_falls = 0;
        m_inh = 0;
        m_inh_data = 0;
        m_err = 1'b0;
        m_oe_done = 2'b11;
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge clk);
        clear_mon();
        @(negedge clk);
        bus.TxData = d;
        bus.Start  = 1'b1;
        @(negedge clk);
        bus.Start  = 1'b0;
    endtask

    task automatic device_frame(input bit ack, input int nclk,
                                input bit inject, output logic [10:0] seen);
        bit ok;
        ok = 1'b0;
        seen = '1;
        for (int i = 0; i < INH + 50; i++) begin
            @(negedge clk);
            if (!bus.PS2ClkOE && bus.PS2ClkIn && !bus.PS2DataIn) begin
                ok = 1'b1;
                break;
            end
        end
        check("rts_seen", ok, 1);
        if (!ok) return;
        seen[0] = bus.PS2DataIn;
        for (int k = 1; k <= nclk; k++) begin
            if (inject && k == 5) begin
                bus.TxData = 8'h55;
                bus.Start  = 1'b1;
                @(negedge clk);
                bus.Start  = 1'b0;
            end
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) seen[k] = bus.PS2DataIn;
            if (k == 10) begin
                repeat (H / 2) @(negedge clk);
                dev_data_low = ack;
            end
            if (k == 11) begin
                repeat (H / 2) @(negedge clk);
                dev_data_low = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (m_done > 0) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " done_seen"}, got, 1);
        @(negedge clk);
        check({tag, " busy_after_done"}, bus.Busy, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d,
                               input logic [10:0] seen, input bit ack);
        logic [10:0] exp;
        exp = frame_model(d);
        for (int i = 0; i < 11; i++)
            check($sformatf("%s bit%0d", tag, i), seen[i], exp[i]);
        check({tag, " done_count"}, m_done, 1);
        check({tag, " ack_error"}, m_err, !ack);
        check({tag, " falls"}, m_falls, 11);
        check({tag, " inhibit_len"}, m_inh, INH);
        check({tag, " inhibit_data"}, m_inh_data, 1);
        check({tag, " oe_at_done"}, m_oe_done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t, limit 400000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] seen;
        bus.Start  = 1'b0;
        bus.TxData = 8'h00;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst busy", bus.Busy, 0);
        check("rst done", bus.Done, 0);
        check("rst ackerr", bus.AckError, 0);
        check("rst clkoe", bus.PS2ClkOE, 0);
        check("rst dataoe", bus.PS2DataOE, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send(8'hED);
        device_frame(1'b1, 11, 1'b0, seen);
        wait_done("ed");
        check_frame("ed", 8'hED, seen, 1'b1);
        check("ed literal", seen, 11'h7DA);

        send(8'hF4);
        device_frame(1'b1, 11, 1'b0, seen);
        wait_done("f4");
        check_frame("f4", 8'hF4, seen, 1'b1);
        check("f4 literal", seen, 11'h5E8);

        send(8'h3C);
        device_frame(1'b0, 11, 1'b0, seen);
        wait_done("noack");
        check_frame("noack", 8'h3C, seen, 1'b0);
        check("noack literal_err", m_err, 1);

        send(8'hED);
        device_frame(1'b1, 11, 1'b1, seen);
        wait_done("inject");
        check_frame("inject", 8'hED, seen, 1'b1);

        send(8'hF4);
`ifdef PS2_TX_TIMEOUT_EN
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < INH + TO + 100; i++) begin
                @(posedge clk);
                if (m_done > 0) begin
                    got = 1'b1;
                    break;
                end
            end
            check("timeout done_seen", got, 1);
            check("timeout ack_error", m_err, 1);
            check("timeout latency", done_cyc - rel_cyc, TO);
            @(negedge clk);
            check("timeout clkoe", bus.PS2ClkOE, 0);
            check("timeout dataoe", bus.PS2DataOE, 0);
            check("timeout busy", bus.Busy, 0);
        end
`else
        repeat (INH + 2 * TO) @(negedge clk);
        check("silent busy", bus.Busy, 1);
        check("silent done_count", m_done, 0);
        check("silent clkoe", bus.PS2ClkOE, 0);
        check("silent dataoe", bus.PS2DataOE, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("silent reset busy", bus.Busy, 0);
`endif
        repeat (5) @(negedge clk);

        send(8'hED);
        device_frame(1'b1, 4, 1'b0, seen);
        check("abort bits", seen[4:0], 5'b11010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort clkoe", bus.PS2ClkOE, 0);
        check("abort dataoe", bus.PS2DataOE, 0);
        check("abort busy", bus.Busy, 0);
        repeat (10) @(negedge clk);
        check("abort done_count", m_done, 0);

        send(8'hA5);
        device_frame(1'b1, 11, 1'b0, seen);
        wait_done("a5");
        check_frame("a5", 8'hA5, seen, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
